// File: rtl/rr_grant_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// spmv_arb_pkg
// Shared types and helpers for the SpMV resource arbiter.
//   arb_state_e : arbiter FSM states (IDLE, BUSY)
//   clog2()     : constant ceil(log2(n)), used to size binary grant indices
// ----------------------------------------------------------------------------
package spmv_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   // Returns 1 for n <= 2 so an index field is never zero-width.
   function automatic int clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// ----------------------------------------------------------------------------
// rr_grant_arbiter_if
// Request/grant bundle between requesters and the round-robin arbiter.
//   req         : level request, one bit per requester
//   grant       : registered one-hot (or zero) owner vector
//   grant_idx   : binary index of the set grant bit, 0 when idle
//   grant_valid : OR of grant
//   burst_cnt   : cycles the current owner has held the grant, 0 when idle
// Modports: master = requester side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface rr_grant_arbiter_if
   import spmv_arb_pkg::*;
#(
   parameter int NUM_REQ   = 8,
   parameter int IDX_WIDTH = clog2(NUM_REQ),
   parameter int CNT_WIDTH = 5
);

   logic [NUM_REQ-1:0]   req;
   logic [NUM_REQ-1:0]   grant;
   logic [IDX_WIDTH-1:0] grant_idx;
   logic                 grant_valid;
   logic [CNT_WIDTH-1:0] burst_cnt;

   modport master (
      output req,
      input  grant, grant_idx, grant_valid, burst_cnt
   );

   modport slave (
      input  req,
      output grant, grant_idx, grant_valid, burst_cnt
   );

endinterface

// File: rtl/rr_grant_arbiter_onehot_to_bin.sv
// ----------------------------------------------------------------------------
// onehot_to_bin
// Converts a one-hot (or all-zero) vector to its binary index.
//   onehot_i : one-hot input, ONEHOT_WIDTH bits
//   bin_o    : binary index, BIN_WIDTH bits; 0 for an all-zero input
// Pure OR-reduction: each index bit is the OR of the one-hot bits whose
// position has that bit set, so no priority chain is built.
// ----------------------------------------------------------------------------
module onehot_to_bin
   import spmv_arb_pkg::*;
#(
   parameter int ONEHOT_WIDTH = 8,
   parameter int BIN_WIDTH    = clog2(ONEHOT_WIDTH)
) (
   input  logic [ONEHOT_WIDTH-1:0] onehot_i,
   output logic [BIN_WIDTH-1:0]    bin_o
);

   always_comb begin
      bin_o = '0;
      for (int i = 0; i < ONEHOT_WIDTH; i++) begin
         if (onehot_i[i]) bin_o = bin_o | BIN_WIDTH'(i);
      end
   end

endmodule

// File: rtl/rr_grant_arbiter.sv
// ----------------------------------------------------------------------------
// rr_grant_arbiter
// Round-robin arbiter with burst limit sharing one SpMV datapath resource
// between NUM_REQ requesters. The owner keeps the grant while it requests,
// for at most MAX_BURST cycles, after which ownership rotates.
//   clk : sole clock, rising edge
//   rst : synchronous, active-high reset
//   bus : rr_grant_arbiter_if.slave (req in; grant, grant_idx,
//         grant_valid, burst_cnt out)
// ----------------------------------------------------------------------------
module rr_grant_arbiter
   import spmv_arb_pkg::*;
#(
   parameter int NUM_REQ   = 8,
   parameter int IDX_WIDTH = clog2(NUM_REQ),
   parameter int MAX_BURST = 16,
   parameter int CNT_WIDTH = 5
) (
   input  logic                clk,
   input  logic                rst,
   rr_grant_arbiter_if.slave   bus
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_BURST);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
   localparam logic [NUM_REQ-1:0]   LAST_RST = {1'b1, {(NUM_REQ-1){1'b0}}};

   arb_state_e           state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [NUM_REQ-1:0]   last_q, last_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   logic [NUM_REQ-1:0]   pick_all;   // winner among all requests
   logic [NUM_REQ-1:0]   pick_oth;   // winner with current holder masked off
   logic                 hold_req;   // holder still requesting

   // Circular priority starting one bit after `last`. The request vector is
   // doubled so the borrow of (req - base) can ripple past the top bit and
   // wrap to bit 0; folding the two halves back gives the one-hot winner.
   function automatic logic [NUM_REQ-1:0] rr_pick(
      input logic [NUM_REQ-1:0] r,
      input logic [NUM_REQ-1:0] last
   );
      logic [NUM_REQ-1:0]   base;
      logic [2*NUM_REQ-1:0] dbl;
      logic [2*NUM_REQ-1:0] win;
      base = {last[NUM_REQ-2:0], last[NUM_REQ-1]};
      dbl  = {r, r};
      win  = dbl & ~(dbl - {{NUM_REQ{1'b0}}, base});
      return win[NUM_REQ-1:0] | win[2*NUM_REQ-1:NUM_REQ];
   endfunction

   assign pick_all = rr_pick(bus.req, last_q);
   assign pick_oth = rr_pick(bus.req & ~grant_q, last_q);
   assign hold_req = |(bus.req & grant_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= LAST_RST;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (|bus.req) begin
               state_d = BUSY;
               grant_d = pick_all;
               last_d  = pick_all;
               cnt_d   = CNT_ONE;
            end
         end
         BUSY: begin
            if (!hold_req) begin
               // Release wins over expiry; req already excludes the holder.
               if (|pick_all) begin
                  grant_d = pick_all;
                  last_d  = pick_all;
                  cnt_d   = CNT_ONE;
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
                  cnt_d   = '0;
               end
            end else if (cnt_q < CNT_MAX) begin
               cnt_d = cnt_q + CNT_ONE;
            end else if (|pick_oth) begin
               grant_d = pick_oth;
               last_d  = pick_oth;
               cnt_d   = CNT_ONE;
            end else begin
               // Sole requester at the limit: fresh ownership, same grant.
               cnt_d = CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   assign bus.grant       = grant_q;
   assign bus.grant_valid = |grant_q;
   assign bus.burst_cnt   = cnt_q;

   onehot_to_bin #(
      .ONEHOT_WIDTH (NUM_REQ),
      .BIN_WIDTH    (IDX_WIDTH)
   ) u_idx (
      .onehot_i (grant_q),
      .bin_o    (bus.grant_idx)
   );

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rr_grant_arbiter
// Directed vector bench for rr_grant_arbiter with NUM_REQ=8, MAX_BURST=4.
// Each vector applies {rst, req} for one cycle and gives the outputs
// expected just after the following rising edge.
// ----------------------------------------------------------------------------
module tb_rr_grant_arbiter;

   localparam int NUM_REQ   = 8;
   localparam int IDX_WIDTH = 3;
   localparam int MAX_BURST = 4;
   localparam int CNT_WIDTH = 5;

   typedef struct {
      logic       rst;
      logic [7:0] req;
      logic [7:0] g;
      logic [2:0] idx;
      logic [4:0] cnt;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   vec_t tbl[$];

   rr_grant_arbiter_if #(
      .NUM_REQ   (NUM_REQ),
      .IDX_WIDTH (IDX_WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
   ) bus ();

   rr_grant_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .IDX_WIDTH (IDX_WIDTH),
      .MAX_BURST (MAX_BURST),
      .CNT_WIDTH (CNT_WIDTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic r, input logic [7:0] q, input logic [7:0] g,
                      input logic [2:0] i, input logic [4:0] c);
      vec_t v;
      v.rst = r; v.req = q; v.g = g; v.idx = i; v.cnt = c;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Apply one cycle of stimulus, then sample just after the edge.
   task automatic step(input logic r, input logic [7:0] q);
      rst     = r;
      bus.req = q;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [7:0] g,
                             input logic [2:0] i, input logic [4:0] c);
      chk({tag, ".grant"},       32'(bus.grant),       32'(g));
      chk({tag, ".grant_idx"},   32'(bus.grant_idx),   32'(i));
      chk({tag, ".grant_valid"}, 32'(bus.grant_valid), 32'(g != 8'h00));
      chk({tag, ".burst_cnt"},   32'(bus.burst_cnt),   32'(c));
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      bus.req  = '0;

      // reset state, reset dominates req
      add(1, 8'h00, 8'h00, 0, 0);
      add(1, 8'h81, 8'h00, 0, 0);
      // reset priority: requester 0 first
      add(0, 8'h81, 8'h01, 0, 1);
      add(0, 8'h81, 8'h01, 0, 2);
      add(0, 8'h81, 8'h01, 0, 3);
      // release handoff to 7, no bubble
      add(0, 8'h80, 8'h80, 7, 1);
      add(0, 8'h80, 8'h80, 7, 2);
      // idle return
      add(0, 8'h00, 8'h00, 0, 0);
      add(0, 8'h00, 8'h00, 0, 0);
      // after 7 last: 0x44 picks 2
      add(0, 8'h44, 8'h04, 2, 1);
      add(0, 8'h00, 8'h00, 0, 0);
      // burst expiry 1 <-> 2
      add(0, 8'h06, 8'h02, 1, 1);
      add(0, 8'h06, 8'h02, 1, 2);
      add(0, 8'h06, 8'h02, 1, 3);
      add(0, 8'h06, 8'h02, 1, 4);
      add(0, 8'h06, 8'h04, 2, 1);
      add(0, 8'h06, 8'h04, 2, 2);
      add(0, 8'h06, 8'h04, 2, 3);
      add(0, 8'h06, 8'h04, 2, 4);
      add(0, 8'h06, 8'h02, 1, 1);
      add(0, 8'h00, 8'h00, 0, 0);
      // sole requester expiry: grant stays, count wraps
      add(0, 8'h20, 8'h20, 5, 1);
      add(0, 8'h20, 8'h20, 5, 2);
      add(0, 8'h20, 8'h20, 5, 3);
      add(0, 8'h20, 8'h20, 5, 4);
      add(0, 8'h20, 8'h20, 5, 1);
      add(0, 8'h20, 8'h20, 5, 2);
      add(0, 8'h00, 8'h00, 0, 0);
      // mid-burst reset at cnt 3, then all-request picks 0
      add(0, 8'h08, 8'h08, 3, 1);
      add(0, 8'h08, 8'h08, 3, 2);
      add(0, 8'h08, 8'h08, 3, 3);
      add(1, 8'h08, 8'h00, 0, 0);
      add(0, 8'hFF, 8'h01, 0, 1);
      add(0, 8'h00, 8'h00, 0, 0);

      foreach (tbl[k]) begin
         step(tbl[k].rst, tbl[k].req);
         expect_out($sformatf("vec%0d", k), tbl[k].g, tbl[k].idx, tbl[k].cnt);
      end

      // A one-cycle request from 5 during 0's ownership is not remembered.
      step(0, 8'h01); expect_out("pulse0", 8'h01, 0, 1);
      step(0, 8'h21); expect_out("pulse1", 8'h01, 0, 2);
      step(0, 8'h01); expect_out("pulse2", 8'h01, 0, 3);
      step(0, 8'h00); expect_out("pulse3", 8'h00, 0, 0);

      // Holder drops exactly at the burst limit: goes idle, not re-granted.
      step(0, 8'h10); expect_out("lim0", 8'h10, 4, 1);
      step(0, 8'h10); expect_out("lim1", 8'h10, 4, 2);
      step(0, 8'h10); expect_out("lim2", 8'h10, 4, 3);
      step(0, 8'h10); expect_out("lim3", 8'h10, 4, 4);
      step(0, 8'h00); expect_out("lim4", 8'h00, 0, 0);

      // Wrap-around: last=4, requests at 1 and 3 -> 1 wins via wrap order
      // 5,6,7,0,1; then 1 expires and 3 takes over.
      step(0, 8'h0A); expect_out("wrap0", 8'h02, 1, 1);
      step(0, 8'h0A); expect_out("wrap1", 8'h02, 1, 2);
      step(0, 8'h0A); expect_out("wrap2", 8'h02, 1, 3);
      step(0, 8'h0A); expect_out("wrap3", 8'h02, 1, 4);
      step(0, 8'h0A); expect_out("wrap4", 8'h08, 3, 1);
      step(0, 8'h00); expect_out("wrap5", 8'h00, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rr_grant_arbiter.md
# rr_grant_arbiter

Round-robin arbiter that shares one SpMV datapath resource, such as a multiplier lane or a memory read port, between `NUM_REQ` requesters. It holds a grant for as long as the owner keeps requesting, up to a burst limit, then forces rotation to the next requester. It presents the owner as a registered one-hot vector, with a binary index beside it for mux selects downstream.

## Interface
- `NUM_REQ`, 8: number of requesters; legal range is 2 or more.
- `IDX_WIDTH`, 3: width of `grant_idx`; must equal ceil(log2(`NUM_REQ`)).
- `MAX_BURST`, 16: maximum consecutive grant cycles per ownership; must be 1 or more.
- `CNT_WIDTH`, 5: width of the burst counter; must be able to hold `MAX_BURST`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  `NUM_REQ`  level request, one bit per requester; the requester holds it high while it wants the resource.
- `grant`  out  `NUM_REQ`  registered; one-hot or all-zero.
- `grant_idx`  out  `IDX_WIDTH`  binary index of the set `grant` bit; 0 when `grant` is 0.
- `grant_valid`  out  1  equals OR of `grant`.
- `burst_cnt`  out  `CNT_WIDTH`  number of cycles the current owner has held the grant, including the present cycle; 0 when idle.

## Operation
- State machine with states IDLE and BUSY. The state register, `grant`, `burst_cnt` and the priority pointer `last` are all registered.
- Reset values:
  - state = IDLE.
  - `grant` = 0, `grant_idx` = 0, `grant_valid` = 0, `burst_cnt` = 0.
  - `last` = one-hot bit `NUM_REQ`-1, so requester 0 has top priority after reset.
- Winner selection uses `req` masked by a candidate set. Priority starts at the bit after `last` and wraps circularly, so bit 0 follows bit `NUM_REQ`-1. Implement it with the double-width mask/subtract method; no loops over time.
- IDLE:
  - If `req` is 0, stay in IDLE.
  - Otherwise grant the winner, go to BUSY, set `burst_cnt` = 1 and set `last` = the winner.
- BUSY, with holder h:
  - Hold: if `req[h]` = 1 and `burst_cnt` < `MAX_BURST`, keep `grant`, increment `burst_cnt` and stay in BUSY.
  - Release (`req[h]` = 0): pick a winner from `req`, which already excludes h. If there is one, switch to it directly with no idle bubble, set `burst_cnt` = 1 and update `last`. If there is none, go to IDLE and clear `grant` and `burst_cnt`.
  - Expiry (`req[h]` = 1 and `burst_cnt` = `MAX_BURST`): pick a winner from `req` with bit h masked off. If one exists, switch to it. If none exists, re-grant h with `burst_cnt` = 1; this counts as a new ownership.
- Release takes precedence over expiry when both conditions hold in the same cycle.
- `rst` asserted mid-burst: on the next edge, all registers return to their reset values regardless of `req`.
- `grant_idx` and `grant_valid` are combinational functions of registered `grant` and carry no added latency.

## Timing
- Request to grant latency: `req` rises in cycle t with the arbiter in IDLE; `grant` is visible in cycle t+1.
- Release handoff: `req[h]` falls in cycle t.
  - `grant[h]` is still high in cycle t. The requester must ignore it.
  - The new grant, or zero, is visible in cycle t+1.
- Maximum continuous ownership is `MAX_BURST` cycles. A waiting requester is granted within (`NUM_REQ`-1)·`MAX_BURST` + 1 cycles of raising `req`, provided its `req` stays high.
- Requests are sampled every cycle. A request that pulses for one cycle while another requester holds the grant is not remembered.

## Structure
- Shared package `spmv_arb_pkg`:
  - state enum {IDLE, BUSY}.
  - A constant function computing ceil(log2) for deriving `IDX_WIDTH`.
- One sub-module: the existing `onehot_to_bin`, instantiated with `ONEHOT_WIDTH`=`NUM_REQ` and `BIN_WIDTH`=`IDX_WIDTH`, driving `grant_idx` from `grant`.
- The round-robin mask/select is a local function, not a separate module.

## Test plan
- Reset priority:
  - Stimulus: assert `rst`, release it, then apply `req` = 8'b1000_0001 from cycle 0.
  - Required: `grant` = 8'b0000_0001 and `grant_idx` = 0 in cycle 1.
- Release rotation:
  - Stimulus: requester 0 drops `req` in cycle 3 while 7 is still requesting.
  - Required: `grant` = 8'b1000_0000, `grant_idx` = 7 and `burst_cnt` = 1 in cycle 4, with no cycle where `grant_valid` = 0.
- Burst expiry:
  - Stimulus: `MAX_BURST` = 4, `req` = 8'b0000_0110 held constant.
  - Required: requester 1 holds the grant for 4 cycles, then requester 2 for 4 cycles, then requester 1 again. `burst_cnt` sequence is 1, 2, 3, 4, 1, …
- Sole requester expiry:
  - Stimulus: `MAX_BURST` = 4, `req` = 8'b0010_0000 held constant.
  - Required: `grant[5]` stays high continuously; `burst_cnt` wraps 4 → 1.
- Idle return:
  - Stimulus: all requests drop while the arbiter is in BUSY.
  - Required: next cycle `grant` = 0, `grant_idx` = 0, `burst_cnt` = 0. A later `req` = 8'b0100_0100 after 7 was last granted yields 2, not 6.
- Mid-burst reset:
  - Stimulus: assert `rst` at `burst_cnt` = 3.
  - Required: all outputs are 0 on the next cycle. After release, `req` = 8'hFF grants requester 0.
